// File: rtl/product_bcd_pkg.sv
// Shared types and constants for the product binary-to-BCD converter.
// 7-segment patterns are active-high, bit order gfedcba.
package product_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int IN_W_DEF   = 17;
  localparam int DIGITS_DEF = 6;

  // Index 15 down to 0; codes 10-15 blank the digit
  localparam logic [15:0][6:0] SEG7_LUT = {
    7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_seg7_dec.sv
// Single BCD digit to active-high 7-segment (gfedcba) decoder.
module bcd_seg7_dec
  import product_bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = SEG7_LUT[digit];

endmodule

// File: rtl/product_bcd_conv.sv
// Sequential double-dabble converter for the multiplier product, one bit per cycle.
// Optional 7-segment readout enabled by defining PRODUCT_BCD_SEG7_EN.
module product_bcd_conv
  import product_bcd_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy
`ifdef PRODUCT_BCD_SEG7_EN
  ,
  output logic [7*DIGITS-1:0]   seg_out
`endif
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  generate
    if (pow10(DIGITS) <= (64'd1 << IN_W)) begin : g_size_check
      $error("product_bcd_conv: DIGITS too small for IN_W");
    end
  endgenerate

  state_t             state, state_nxt;
  logic [IN_W-1:0]    bin_sr;
  logic [BCD_W-1:0]   bcd_sr;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shifted;
  logic [CNT_W-1:0]   cnt;
  logic               last_shift;

  // Per-digit add-3 correction; each digit wraps within 4 bits, no inter-digit carry
  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    logic [3:0]       d;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = b[4*i +: 4];
      r[4*i +: 4] = (d >= 4'd5) ? (d + 4'd3) : d;
    end
    return r;
  endfunction

  assign bcd_adj     = dabble_adj(bcd_sr);
  assign bcd_shifted = {bcd_adj[BCD_W-2:0], bin_sr[IN_W-1]};
  assign last_shift  = (state == SHIFT) && (cnt == CNT_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Output register only updates on the edge entering DONE
  always_ff @(posedge clk) begin
    if (!rst)            bcd_q <= '0;
    else if (last_shift) bcd_q <= bcd_shifted;
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      bin_sr <= bin_in;
      bcd_sr <= '0;
      cnt    <= CNT_W'(IN_W);
    end else if (state == SHIFT) begin
      bin_sr <= {bin_sr[IN_W-2:0], 1'b0};
      bcd_sr <= bcd_shifted;
      cnt    <= cnt - 1'b1;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == SHIFT);
  assign bcd_out   = bcd_q;

`ifdef PRODUCT_BCD_SEG7_EN
  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
      bcd_seg7_dec u_dec (
        .digit (bcd_q[4*g +: 4]),
        .seg   (seg_out[7*g +: 7])
      );
    end
  endgenerate
`endif

endmodule
